multi_cycle_ctrl: RTL and testbench

MULTI_CYCLE_CTRL -- requirements
Module: multi_cycle_ctrl

---
 rtl/multi_cycle_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_multi_cycle_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/multi_cycle_ctrl.sv
// multi_cycle_ctrl: control FSM for a multi-cycle MIPS-style datapath.
// Sequences FETCH -> DECODE -> EXEC -> (MEM) -> (WB) per instruction and
// decodes datapath controls from the registered state and opcode. The PC and
// IR write strobes follow mem_ready and zero in the same cycle. All outputs
// are forced low and the debug state reads FETCH while rst is high.
module multi_cycle_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       iord,
  output logic       ir_we,
  output logic       pc_we,
  output logic [1:0] pc_src,
  output logic       reg_we,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       ext_signal,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_FETCH   = 3'd0,
    S_DECODE  = 3'd1,
    S_EXEC    = 3'd2,
    S_MEM     = 3'd3,
    S_WB      = 3'd4,
    S_ILLEGAL = 3'd7
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_LUI  = 6'b001111;
  localparam logic [5:0] OP_J    = 6'b000010;

  // Datapath control bundle; grouped so reset gating is a single assignment.
  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       iord;
    logic       ir_we;
    logic       pc_we;
    logic [1:0] pc_src;
    logic       reg_we;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       ext_signal;
  } ctrl_t;

  state_t     r_state;
  state_t     w_next;
  logic [5:0] r_opcode;
  logic       w_supported;
  ctrl_t      w_ctrl;
  ctrl_t      w_out;

  // Opcode legality check on the live IR field, used only while in DECODE.
  always_comb begin
    w_supported = 1'b0;
    case (opcode)
      OP_R, OP_LW, OP_SW, OP_BEQ, OP_ADDI,
      OP_ANDI, OP_ORI, OP_LUI, OP_J: w_supported = 1'b1;
      default:                       w_supported = 1'b0;
    endcase
  end

  // State register; the opcode is captured on the edge that leaves DECODE so
  // later states are immune to the IR field changing underneath them.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_FETCH;
      r_opcode <= 6'b000000;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE) r_opcode <= opcode;
    end
  end

  // Next-state logic; mem_ready is only looked at in FETCH and MEM.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH:  if (mem_ready) w_next = S_DECODE;
      S_DECODE: w_next = w_supported ? S_EXEC : S_ILLEGAL;
      S_EXEC: begin
        case (r_opcode)
          OP_R, OP_ADDI, OP_ANDI, OP_ORI, OP_LUI: w_next = S_WB;
          OP_LW, OP_SW:                           w_next = S_MEM;
          OP_BEQ, OP_J:                           w_next = S_FETCH;
          default:                                w_next = S_ILLEGAL;
        endcase
      end
      S_MEM:     if (mem_ready) w_next = (r_opcode == OP_SW) ? S_FETCH : S_WB;
      S_WB:      w_next = S_FETCH;
      S_ILLEGAL: w_next = S_ILLEGAL;
      default:   w_next = S_ILLEGAL;
    endcase
  end

  // Output decode from registered state/opcode, plus same-cycle PC/IR strobes.
  always_comb begin
    w_ctrl = '0;
    case (r_state)
      S_FETCH: begin
        w_ctrl.mem_req   = 1'b1;
        w_ctrl.alu_src_b = 2'b01;
        w_ctrl.ir_we     = mem_ready;
        w_ctrl.pc_we     = mem_ready;
      end
      S_DECODE: begin
        w_ctrl.alu_src_b = 2'b11;
      end
      S_EXEC: begin
        case (r_opcode)
          OP_R: begin
            w_ctrl.alu_src_a = 1'b1;
            w_ctrl.alu_op    = 2'b10;
          end
          OP_LW, OP_SW, OP_ADDI: begin
            w_ctrl.alu_src_b = 2'b10;
          end
          OP_ANDI, OP_ORI, OP_LUI: begin
            w_ctrl.alu_src_b  = 2'b10;
            w_ctrl.alu_op     = 2'b11;
            w_ctrl.ext_signal = 1'b1;
          end
          OP_BEQ: begin
            w_ctrl.alu_src_a = 1'b1;
            w_ctrl.alu_op    = 2'b01;
            w_ctrl.pc_src    = 2'b01;
            w_ctrl.pc_we     = zero;
          end
          OP_J: begin
            w_ctrl.pc_src = 2'b10;
            w_ctrl.pc_we  = 1'b1;
          end
          default: w_ctrl = '0;
        endcase
      end
      S_MEM: begin
        w_ctrl.mem_req = 1'b1;
        w_ctrl.iord    = 1'b1;
        w_ctrl.mem_we  = (r_opcode == OP_SW);
      end
      S_WB: begin
        w_ctrl.reg_we     = 1'b1;
        w_ctrl.reg_dst    = (r_opcode == OP_R);
        w_ctrl.mem_to_reg = (r_opcode == OP_LW);
      end
      default: w_ctrl = '0;
    endcase
  end

  assign w_out      = rst ? '0 : w_ctrl;
  assign state      = rst ? 3'd0 : r_state;
  assign mem_req    = w_out.mem_req;
  assign mem_we     = w_out.mem_we;
  assign iord       = w_out.iord;
  assign ir_we      = w_out.ir_we;
  assign pc_we      = w_out.pc_we;
  assign pc_src     = w_out.pc_src;
  assign reg_we     = w_out.reg_we;
  assign reg_dst    = w_out.reg_dst;
  assign mem_to_reg = w_out.mem_to_reg;
  assign alu_src_a  = w_out.alu_src_a;
  assign alu_src_b  = w_out.alu_src_b;
  assign alu_op     = w_out.alu_op;
  assign ext_signal = w_out.ext_signal;

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Scoreboard bench for multi_cycle_ctrl: a per-instruction schedule model
// pushes one expected observation per clock; a negedge monitor pops/compares.
module tb_multi_cycle_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] opcode = '0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       mem_req, mem_we, iord, ir_we, pc_we, reg_we, reg_dst, mem_to_reg;
  logic       alu_src_a, ext_signal;
  logic [1:0] pc_src, alu_src_b, alu_op;
  logic [2:0] state;

  multi_cycle_ctrl dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .ir_we(ir_we),
    .pc_we(pc_we), .pc_src(pc_src), .reg_we(reg_we), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .ext_signal(ext_signal), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] st;
    logic       mem_req, mem_we, iord, ir_we, pc_we;
    logic [1:0] pc_src;
    logic       reg_we, reg_dst, mem_to_reg, alu_src_a;
    logic [1:0] alu_src_b, alu_op;
    logic       ext;
  } obs_t;

  localparam logic [5:0] R = 6'b000000, LW = 6'b100011, SW = 6'b101011,
    BEQ = 6'b000100, ADDI = 6'b001000, ANDI = 6'b001100, ORI = 6'b001101,
    LUI = 6'b001111, J = 6'b000010;

  obs_t  exp_q[$];
  string tag_q[$];
  int    checks = 0, failures = 0, cyc = 0;
  obs_t  act, m_exp;
  string m_tag;

  always_comb act = {state, mem_req, mem_we, iord, ir_we, pc_we, pc_src,
                     reg_we, reg_dst, mem_to_reg, alu_src_a, alu_src_b,
                     alu_op, ext_signal};

  // Monitor: every clock the DUT presents a control word; compare against
  // the oldest expectation.
  always @(negedge clk) begin
    cyc++;
    if (exp_q.size() > 0) begin
      m_exp = exp_q.pop_front();
      m_tag = tag_q.pop_front();
      checks++;
      if (act !== m_exp) begin
        failures++;
        $display("FAIL %s cyc=%0d got st=%0d ctl=%h want st=%0d ctl=%h",
                 m_tag, cyc, act.st, act[17:0], m_exp.st, m_exp[17:0]);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: bench did not finish, queue=%0d", exp_q.size());
    $fatal(1);
  end

  function automatic bit supported(input logic [5:0] op);
    return op inside {R, LW, SW, BEQ, ADDI, ANDI, ORI, LUI, J};
  endfunction

  // ---- reference model: expected control word for each phase ----
  function automatic obs_t e_fetch(input logic done);
    obs_t e = '0;
    e.mem_req = 1; e.alu_src_b = 2'b01; e.ir_we = done; e.pc_we = done;
    return e;
  endfunction

  function automatic obs_t e_decode();
    obs_t e = '0;
    e.st = 3'd1; e.alu_src_b = 2'b11;
    return e;
  endfunction

  function automatic obs_t e_exec(input logic [5:0] op, input logic z);
    obs_t e = '0;
    e.st = 3'd2;
    if (op == R)                      begin e.alu_src_a = 1; e.alu_op = 2'b10; end
    if (op inside {LW, SW, ADDI})     e.alu_src_b = 2'b10;
    if (op inside {ANDI, ORI, LUI})   begin e.alu_src_b = 2'b10; e.alu_op = 2'b11; e.ext = 1; end
    if (op == BEQ) begin e.alu_src_a = 1; e.alu_op = 2'b01; e.pc_src = 2'b01; e.pc_we = z; end
    if (op == J)                      begin e.pc_src = 2'b10; e.pc_we = 1; end
    return e;
  endfunction

  function automatic obs_t e_mem(input logic is_sw);
    obs_t e = '0;
    e.st = 3'd3; e.mem_req = 1; e.iord = 1; e.mem_we = is_sw;
    return e;
  endfunction

  function automatic obs_t e_wb(input logic [5:0] op);
    obs_t e = '0;
    e.st = 3'd4; e.reg_we = 1; e.reg_dst = (op == R); e.mem_to_reg = (op == LW);
    return e;
  endfunction

  function automatic obs_t e_ill();
    obs_t e = '0;
    e.st = 3'd7;
    return e;
  endfunction

  function automatic logic [5:0] r6();  return 6'($urandom); endfunction
  function automatic logic       r1();  return 1'($urandom); endfunction

  // Drive one cycle of inputs and log what the DUT must show in that cycle.
  task automatic step(input logic r, input logic [5:0] op, input logic z,
                      input logic mr, input obs_t e, input string t);
    rst = r; opcode = op; zero = z; mem_ready = mr;
    exp_q.push_back(e); tag_q.push_back(t);
    @(posedge clk); #1;
  endtask

  // One instruction: opcode is only meaningful in DECODE; elsewhere it is
  // randomised so the latched copy is what gets exercised.
  task automatic run_instr(input logic [5:0] op, input int fw, input int mw,
                           input logic z, input int rst_in_mem, input int ill_n);
    for (int i = 0; i < fw; i++) step(0, r6(), r1(), 0, e_fetch(0), "fetch_wait");
    step(0, r6(), r1(), 1, e_fetch(1), "fetch");
    step(0, op, r1(), r1(), e_decode(), "decode");
    if (!supported(op)) begin
      for (int i = 0; i < ill_n; i++) step(0, r6(), r1(), r1(), e_ill(), "illegal_hold");
      step(1, r6(), r1(), r1(), obs_t'(0), "rst_from_illegal");
      return;
    end
    step(0, r6(), (op == BEQ) ? z : r1(), r1(), e_exec(op, z), "exec");
    if (op inside {LW, SW}) begin
      for (int i = 0; i < mw; i++) begin
        if (i == rst_in_mem) begin
          step(1, r6(), r1(), r1(), obs_t'(0), "rst_in_mem");
          return;
        end
        step(0, r6(), r1(), 0, e_mem(op == SW), "mem_wait");
      end
      step(0, r6(), r1(), 1, e_mem(op == SW), "mem_done");
      if (op == SW) return;
    end
    if (op inside {BEQ, J}) return;
    step(0, r6(), r1(), r1(), e_wb(op), "wb");
  endtask

  logic [5:0] ops[9] = '{R, LW, SW, BEQ, ADDI, ANDI, ORI, LUI, J};

  initial begin
    logic [5:0] op;
    int mw, rim;
    @(posedge clk); #1;
    // reset: everything low, state reads 0
    step(1, r6(), r1(), 1, obs_t'(0), "reset");
    step(1, r6(), r1(), 1, obs_t'(0), "reset");
    // directed cases
    run_instr(R,    0, 0, 0, -1, 0);
    run_instr(ORI,  0, 0, 0, -1, 0);
    run_instr(ADDI, 1, 0, 0, -1, 0);
    run_instr(LW,   0, 3, 0, -1, 0);
    run_instr(BEQ,  0, 0, 1, -1, 0);
    run_instr(BEQ,  2, 0, 0, -1, 0);
    run_instr(J,    0, 0, 0, -1, 0);
    run_instr(SW,   0, 2, 0, -1, 0);
    run_instr(6'b111111, 0, 0, 0, -1, 10);
    run_instr(SW,   0, 3, 0, 1, 0);
    run_instr(LUI,  0, 0, 0, -1, 0);
    // randomized traffic
    for (int n = 0; n < 250; n++) begin
      if ($urandom_range(0, 9) == 0) begin
        do op = r6(); while (supported(op));
      end else begin
        op = ops[$urandom_range(0, 8)];
      end
      mw  = $urandom_range(0, 3);
      rim = (mw > 0 && $urandom_range(0, 7) == 0) ? $urandom_range(0, mw - 1) : -1;
      run_instr(op, $urandom_range(0, 2), mw, r1(), rim, $urandom_range(1, 4));
    end
    rst = 0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
